fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction-region bounds, reset vector,
// fetch buffer geometry and the fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned XLEN        = 16;
  localparam int unsigned INST_TOP    = 1023;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam int unsigned FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  // Instruction addresses are halfword aligned; bit 0 is always dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer. The head entry lives in its own register so
// decode-facing outputs never see a combinational path from push data.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [FETCH_CNT_W-1:0] CNT_ZERO = FETCH_CNT_W'(0);
  localparam logic [FETCH_CNT_W-1:0] CNT_ONE  = FETCH_CNT_W'(1);
  localparam logic [FETCH_CNT_W-1:0] CNT_FULL = FETCH_CNT_W'(FETCH_DEPTH);

  logic [FETCH_CNT_W-1:0] count_q, count_d;
  fetch_entry_t           head_q, head_d;
  fetch_entry_t           tail_q, tail_d;
  logic                   do_push, do_pop;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop_i && (count_q != CNT_ZERO);
    do_push = push_i && ((count_q != CNT_FULL) || do_pop);

    if (flush_i) begin
      count_d = CNT_ZERO;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == CNT_ZERO) begin
            head_d = data_i;
          end else begin
            tail_d = data_i;
          end
          count_d = count_q + CNT_ONE;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_ONE;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; with one entry the new
          // word becomes the head directly.
          if (count_q == CNT_ONE) begin
            head_d = data_i;
          end else begin
            head_d = tail_q;
            tail_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CNT_ZERO;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == CNT_ZERO);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, shared memory port arbitration,
// redirect handling, region-bound fault and a 2-entry decoupling buffer.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned INST_TOP = cpu_pkg::INST_TOP
) (
  input  logic        clk,
  input  logic        rest,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  output logic        fetch_fault
);

  import cpu_pkg::XLEN;
  import cpu_pkg::fetch_state_e;
  import cpu_pkg::fetch_entry_t;
  import cpu_pkg::align_pc;
  import cpu_pkg::RUN;
  import cpu_pkg::FAULT;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            pop_c, push_c, flush_c;
  logic            slot_free_c, in_range_c, attempt_c;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, push_data;

  assign pop_c       = !fifo_empty && inst_ready;
  assign slot_free_c = !fifo_full || pop_c;
  // Bound check in 32 bits so pc wrap-around can never slip past it.
  assign in_range_c  = (32'(pc_q) + 32'd1) <= 32'(INST_TOP);
  assign attempt_c   = (state_q == RUN) && !mem_busy && slot_free_c;
  assign push_data   = '{pc: pc_q, word: mem_rdata};

  // Redirect outranks both memory stalls and fault entry.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_c  = 1'b0;
    flush_c = 1'b0;

    if (redirect_valid) begin
      flush_c = 1'b1;
      pc_d    = align_pc(redirect_pc);
      state_d = RUN;
    end else if (attempt_c) begin
      if (in_range_c) begin
        push_c = 1'b1;
        pc_d   = pc_q + PC_STEP;
      end else begin
        state_d = FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= RUN;
      pc_q    <= align_pc(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i   (clk),
    .rst_i   (rest),
    .flush_i (flush_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (push_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_addr    = pc_q;
  assign inst_valid  = !fifo_empty;
  assign inst_data   = fifo_head.word;
  assign inst_pc     = fifo_head.pc;
  assign fetch_fault = (state_q == FAULT);

endmodule
